mov_izquierda_seq: RTL and testbench

Sequential left-move engine for the 2048 game datapath. It is the opposite direction of the combinational right-move block. It latches a 4x4 board on `start` and processes one row per clock: compress toward column 0, then merge equal neighbours once each. It then reports the new board, a moved flag and, optionally, the merge score. The game controller uses it for the LEFT command.

---
 rtl/juego_pkg.sv | 17 +
 rtl/mov_izquierda_seq_if.sv | 36 +++
 rtl/fila_izquierda.sv | 56 +++++
 rtl/mov_izquierda_seq.sv | 89 ++++++++
 tb/tb_mov_izquierda_seq.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/juego_pkg.sv
// Shared 2048 datapath types: board geometry, tile/row/board types and the
// move-engine state encoding used by every direction block and the controller.
package juego_pkg;

  localparam int N = 4;

  typedef int tile_t;
  typedef tile_t row_t [N];
  typedef row_t matrix_t [N];

  typedef enum logic [1:0] {
    IDLE,
    ROW,
    DONE
  } mov_state_t;

endpackage

// File: rtl/mov_izquierda_seq_if.sv
// Request/result bundle between the game controller (master) and the left-move
// engine (slave). The puntos score signal exists only when MOV_SCORE_EN is defined.
interface mov_izquierda_seq_if;
  import juego_pkg::*;

  logic    start;
  matrix_t input_matrix;
  matrix_t output_matrix;
  int      mov;
  logic    busy;
  logic    done;
`ifdef MOV_SCORE_EN
  int      puntos;

  modport master (
    output start, input_matrix,
    input  output_matrix, mov, busy, done, puntos
  );

  modport slave (
    input  start, input_matrix,
    output output_matrix, mov, busy, done, puntos
  );
`else
  modport master (
    output start, input_matrix,
    input  output_matrix, mov, busy, done
  );

  modport slave (
    input  start, input_matrix,
    output output_matrix, mov, busy, done
  );
`endif

endinterface

// File: rtl/fila_izquierda.sv
// Combinational left move of one row: compress toward column 0, merge equal
// neighbours once each. Merge sum output exists only with MOV_SCORE_EN.
module fila_izquierda
  import juego_pkg::*;
(
  input  row_t  fila,
  output row_t  resultado,
  output logic  cambio
`ifdef MOV_SCORE_EN
  ,
  output tile_t suma
`endif
);

  logic [1:0] pos;
  logic [1:0] ultimo;
  tile_t      previo;
  logic       pendiente;

  // NOTE: blocking assignments are correct here; the scan is a sequential
  // algorithm unrolled into combinational logic, and every variable gets a
  // default first so no latch is inferred.
  always_comb begin
    resultado = '{default: 0};
    pos       = '0;
    ultimo    = '0;
    previo    = 0;
    pendiente = 1'b0;
    cambio    = 1'b0;
`ifdef MOV_SCORE_EN
    suma      = 0;
`endif
    for (int c = 0; c < N; c++) begin
      if (fila[c] != 0) begin
        if (pendiente && fila[c] == previo) begin
          // Clearing pendiente stops the doubled tile from merging again.
          resultado[ultimo] = previo * 2;
          pendiente         = 1'b0;
`ifdef MOV_SCORE_EN
          suma              = suma + previo * 2;
`endif
        end else begin
          resultado[pos] = fila[c];
          ultimo         = pos;
          pos            = pos + 2'd1;
          previo         = fila[c];
          pendiente      = 1'b1;
        end
      end
    end
    for (int c = 0; c < N; c++) begin
      if (resultado[c] != fila[c]) cambio = 1'b1;
    end
  end

endmodule

// File: rtl/mov_izquierda_seq.sv
// Sequential left-move engine: latches a board on start, moves one row per
// cycle through fila_izquierda, then pulses done. MOV_SCORE_EN adds puntos.
module mov_izquierda_seq #(
  parameter int N = 4
) (
  input logic               clk,
  input logic               rst,
  mov_izquierda_seq_if.slave bus
);
  import juego_pkg::*;

  localparam logic [1:0] ULTIMA = 2'(N - 1);

  mov_state_t state;
  logic [1:0] r;
  matrix_t    tablero;
  row_t       fila_sel;
  row_t       fila_res;
  logic       cambio;
`ifdef MOV_SCORE_EN
  tile_t      suma;
`endif

  always_comb fila_sel = tablero[r];

  fila_izquierda u_fila (
    .fila      (fila_sel),
    .resultado (fila_res),
    .cambio    (cambio)
`ifdef MOV_SCORE_EN
    ,
    .suma      (suma)
`endif
  );

  // NOTE: the latched board is pure data storage with no reset; ROW is only
  // ever entered through a fresh latch, so its power-up contents are never used.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) tablero <= bus.input_matrix;
  end

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      r                 <= '0;
      bus.output_matrix <= '{default: '{default: 0}};
      bus.mov           <= 0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
`ifdef MOV_SCORE_EN
      bus.puntos        <= 0;
`endif
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= ROW;
            r        <= '0;
            bus.mov  <= 0;
            bus.busy <= 1'b1;
`ifdef MOV_SCORE_EN
            bus.puntos <= 0;
`endif
          end
        end
        ROW: begin
          bus.output_matrix[r] <= fila_res;
          if (cambio) bus.mov <= 1;
`ifdef MOV_SCORE_EN
          bus.puntos <= bus.puntos + suma;
`endif
          if (r == ULTIMA) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            r <= r + 2'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mov_izquierda_seq.sv
// Directed self-checking bench for mov_izquierda_seq; score checks are active
// when MOV_SCORE_EN is defined.
module tb_mov_izquierda_seq;
  import juego_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mov_izquierda_seq_if bus ();

  mov_izquierda_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  matrix_t zero_b   = '{'{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}};
  matrix_t mixed_in = '{'{0,2,2,0}, '{0,4,2,2}, '{2,2,4,0}, '{4,2,2,4}};
  matrix_t mixed_ex = '{'{4,0,0,0}, '{4,4,0,0}, '{4,4,0,0}, '{4,4,4,0}};
  matrix_t left_in  = '{'{2,4,8,16}, '{2,0,0,0}, '{4,2,0,0}, '{0,0,0,0}};
  matrix_t twos_in  = '{'{2,2,2,2}, '{2,2,2,2}, '{2,2,2,2}, '{2,2,2,2}};
  matrix_t twos_ex  = '{'{4,4,0,0}, '{4,4,0,0}, '{4,4,0,0}, '{4,4,0,0}};
  matrix_t once_in  = '{'{2,2,2,2}, '{2,2,2,2}, '{4,4,8,0}, '{2,0,0,2}};
  matrix_t once_ex  = '{'{4,4,0,0}, '{4,4,0,0}, '{8,8,0,0}, '{4,0,0,0}};

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_matrix(input string tag, input matrix_t exp);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("%s[%0d][%0d]", tag, i, j), bus.output_matrix[i][j], exp[i][j]);
  endtask

  task automatic check_results(input string tag, input matrix_t exp,
                               input int exp_mov, input int exp_puntos);
    check_matrix(tag, exp);
    check({tag, "_mov"}, bus.mov, exp_mov);
`ifdef MOV_SCORE_EN
    check({tag, "_puntos"}, bus.puntos, exp_puntos);
`else
    if (exp_puntos < 0) check({tag, "_puntos_arg"}, exp_puntos, 0);
`endif
  endtask

  // Drives one move from IDLE and checks busy/done through the done cycle.
  // poke_at=i drives alt (and start=poke_start) for sampling on edge k+i.
  task automatic run_move(input string tag, input matrix_t m, input matrix_t alt,
                          input int poke_at, input bit poke_start);
    bus.input_matrix = m;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_busy_k%0d", tag, i), bus.busy, 1);
      check($sformatf("%s_done_k%0d", tag, i), bus.done, 0);
      if (poke_at == i + 1) begin
        bus.input_matrix = alt;
        bus.start        = poke_start;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    check({tag, "_done_k4"}, bus.done, 1);
    check({tag, "_busy_k4"}, bus.busy, 0);
  endtask

  task automatic finish_move(input string tag);
    tick();
    check({tag, "_done_k5"}, bus.done, 0);
    check({tag, "_busy_k5"}, bus.busy, 0);
    tick();
    check({tag, "_done_k6"}, bus.done, 0);
    check({tag, "_busy_k6"}, bus.busy, 0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.input_matrix = zero_b;
    tick();
    tick();
    rst = 1'b0;

    check_results("reset", zero_b, 0, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);

    run_move("mixed", mixed_in, mixed_in, 0, 1'b0);
    check_results("mixed", mixed_ex, 1, 16);
    finish_move("mixed");

    run_move("left", left_in, left_in, 0, 1'b0);
    check_results("left", left_in, 0, 0);
    finish_move("left");

    run_move("twos", twos_in, twos_in, 0, 1'b0);
    check_results("twos", twos_ex, 1, 32);
    finish_move("twos");

    // Second start two cycles in, carrying a different board: must be ignored.
    run_move("busy_start", mixed_in, twos_in, 2, 1'b1);
    check_results("busy_start", mixed_ex, 1, 16);
    finish_move("busy_start");

    // Board changes one cycle after the latch edge without a new start.
    run_move("late_input", once_in, zero_b, 1, 1'b0);
    check_results("late_input", once_ex, 1, 28);
    finish_move("late_input");

    // Reset arriving on the edge after row 1 is written.
    bus.input_matrix = mixed_in;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("midrst_row0_new", bus.output_matrix[0][1], 0);
    check("midrst_row2_old", bus.output_matrix[2][0], 8);
    check("midrst_busy_pre", bus.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_results("midrst", zero_b, 0, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    tick();
    check("midrst_idle_busy", bus.busy, 0);
    check("midrst_idle_done", bus.done, 0);

    run_move("after_rst", left_in, left_in, 0, 1'b0);
    check_results("after_rst", left_in, 0, 0);
    finish_move("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
